shift_rows_pipe: RTL and testbench

SHIFT_ROWS_PIPE -- requirements
Module: shift_rows_pipe

---
 rtl/shift_rows_pipe.sv | 128 ++++++++++++
 tb/tb_shift_rows_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_pipe.sv
// Registered Rijndael ShiftRows / InvShiftRows stage with a valid/ready handshake and block count.
// Define SHIFT_ROWS_SKID_EN to add a one-entry skid buffer so in_ready is a register output.
module shift_rows_pipe #(
  parameter int unsigned NB    = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [32*NB-1:0]    in_data,
  input  logic                in_inv,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [32*NB-1:0]    out_data,
  output logic                out_inv,
  output logic [CNT_W-1:0]    blk_count
);

  localparam int NbI = NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $fatal(1, "shift_rows_pipe: NB must be 4, 6 or 8");
  end

  // Nb=8 states use the wider 1/3/4 offsets for rows 1..3.
  function automatic int row_off(input int r);
    if (r == 0) return 0;
    if (NbI == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic logic [32*NB-1:0] f_shift(input logic [32*NB-1:0] d, input logic inv);
    logic [32*NB-1:0] res;
    int               off;
    int               src;
    res = '0;
    for (int c = 0; c < NbI; c++) begin
      for (int r = 0; r < 4; r++) begin
        off = row_off(r);
        src = inv ? (c + NbI - off) % NbI : (c + off) % NbI;
        res[32*NbI-1-32*c-8*r -: 8] = d[32*NbI-1-32*src-8*r -: 8];
      end
    end
    return res;
  endfunction

  logic [32*NB-1:0] w_shift;
  logic             w_accept;
  logic             w_out_hs;
  logic             r_out_valid;
  logic [32*NB-1:0] r_out_data;
  logic             r_out_inv;
  logic [CNT_W-1:0] r_blk_count;

  assign w_shift  = f_shift(in_data, in_inv);
  assign w_accept = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

`ifdef SHIFT_ROWS_SKID_EN
  logic             r_skid_valid;
  logic [32*NB-1:0] r_skid_data;
  logic             r_skid_inv;
  logic             w_out_free;

  assign in_ready   = !rst && !r_skid_valid;
  assign w_out_free = !r_out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_inv    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_inv   <= 1'b0;
    end else if (w_out_free) begin
      // A parked block always goes out before anything new; in_ready is low while it waits.
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_inv    <= r_skid_inv;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_shift;
        r_out_inv   <= in_inv;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_shift;
      r_skid_inv   <= in_inv;
    end
  end
`else
  assign in_ready = !rst && (!r_out_valid || out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_inv   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_shift;
      r_out_inv   <= in_inv;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blk_count <= '0;
    end else if (w_out_hs) begin
      r_blk_count <= r_blk_count + CNT_W'(1);
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_inv   = r_out_inv;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Directed bench for shift_rows_pipe: NB=4 main instance plus an NB=8, CNT_W=4 instance.
module tb_shift_rows_pipe;

  localparam logic [127:0] VecA = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] VecB = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         v4 = 1'b0, rdy4, inv4 = 1'b0, ov4, ordy4 = 1'b1, oinv4;
  logic [127:0] d4 = '0, od4;
  logic [15:0]  cnt4;

  logic         v8 = 1'b0, rdy8, inv8 = 1'b0, ov8, ordy8 = 1'b1, oinv8;
  logic [255:0] d8 = '0, od8;
  logic [3:0]   cnt8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  shift_rows_pipe #(.NB(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rdy4), .in_data(d4), .in_inv(inv4),
    .out_valid(ov4), .out_ready(ordy4), .out_data(od4), .out_inv(oinv4), .blk_count(cnt4)
  );

  shift_rows_pipe #(.NB(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_inv(inv8),
    .out_valid(ov8), .out_ready(ordy8), .out_data(od8), .out_inv(oinv8), .blk_count(cnt8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every column identical, so ShiftRows leaves the block unchanged in either direction.
  function automatic logic [127:0] blk(input int i);
    logic [31:0] w;
    w = {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
    return {4{w}};
  endfunction

  function automatic logic [255:0] nb8_in();
    logic [255:0] res;
    for (int c = 0; c < 8; c++) begin
      res[255-32*c -: 32] = {8'(4*c), 8'(4*c + 1), 8'(4*c + 2), 8'(4*c + 3)};
    end
    return res;
  endfunction

  task automatic do_reset();
    v4 = 1'b0; v8 = 1'b0; ordy4 = 1'b1; ordy8 = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    n_checks++; if (rdy4 !== 1'b0) $display("FAIL rst_in_ready got %b want 0", rdy4); else n_pass++;
    n_checks++; if (ov4 !== 1'b0) $display("FAIL rst_out_valid got %b want 0", ov4); else n_pass++;
    n_checks++; if (od4 !== '0) $display("FAIL rst_out_data got %h want 0", od4); else n_pass++;
    n_checks++; if (oinv4 !== 1'b0) $display("FAIL rst_out_inv got %b want 0", oinv4); else n_pass++;
    n_checks++; if (cnt4 !== 16'd0) $display("FAIL rst_count got %0d want 0", cnt4); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (rdy4 !== 1'b1) $display("FAIL post_rst_ready got %b want 1", rdy4); else n_pass++;
  endtask

  task automatic test_forward();
    v4 = 1'b1; d4 = VecA; inv4 = 1'b0; ordy4 = 1'b1;
    tick();
    v4 = 1'b0;
    #1;
    n_checks++; if (ov4 !== 1'b1) $display("FAIL fwd_valid got %b want 1", ov4); else n_pass++;
    n_checks++; if (od4 !== VecB) $display("FAIL fwd_data got %h want %h", od4, VecB); else n_pass++;
    n_checks++; if (oinv4 !== 1'b0) $display("FAIL fwd_inv got %b want 0", oinv4); else n_pass++;
  endtask

  task automatic test_inverse();
    v4 = 1'b1; d4 = VecB; inv4 = 1'b1;
    tick();
    v4 = 1'b0;
    #1;
    n_checks++; if (ov4 !== 1'b1) $display("FAIL inv_valid got %b want 1", ov4); else n_pass++;
    n_checks++; if (od4 !== VecA) $display("FAIL inv_data got %h want %h", od4, VecA); else n_pass++;
    n_checks++; if (oinv4 !== 1'b1) $display("FAIL inv_inv got %b want 1", oinv4); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    v4 = 1'b1; d4 = VecA; inv4 = 1'b0; ordy4 = 1'b1;
    tick();
    d4 = VecB; inv4 = 1'b1;
    #1;
    n_checks++; if (od4 !== VecB || oinv4 !== 1'b0)
      $display("FAIL b2b_first got %h/%b want %h/0", od4, oinv4, VecB); else n_pass++;
    n_checks++; if (rdy4 !== 1'b1) $display("FAIL b2b_ready got %b want 1", rdy4); else n_pass++;
    tick();
    v4 = 1'b0;
    #1;
    n_checks++; if (ov4 !== 1'b1 || od4 !== VecA || oinv4 !== 1'b1)
      $display("FAIL b2b_second got %b/%h/%b want 1/%h/1", ov4, od4, oinv4, VecA); else n_pass++;
    tick();
    n_checks++; if (ov4 !== 1'b0) $display("FAIL b2b_drain got %b want 0", ov4); else n_pass++;
  endtask

  task automatic test_nb8();
    logic [255:0] q;
    v8 = 1'b1; d8 = nb8_in(); inv8 = 1'b0; ordy8 = 1'b1;
    tick();
    v8 = 1'b0;
    #1;
    n_checks++; if (od8[255 -: 32] !== 32'h00050e13)
      $display("FAIL nb8_col0 got %h want 00050e13", od8[255 -: 32]); else n_pass++;
    n_checks++; if (od8[31:0] !== 32'h1c010a0f)
      $display("FAIL nb8_col7 got %h want 1c010a0f", od8[31:0]); else n_pass++;
    q = od8;
    v8 = 1'b1; d8 = q; inv8 = 1'b1;
    tick();
    v8 = 1'b0;
    #1;
    n_checks++; if (od8 !== nb8_in())
      $display("FAIL nb8_roundtrip got %h want %h", od8, nb8_in()); else n_pass++;
    n_checks++; if (oinv8 !== 1'b1) $display("FAIL nb8_inv got %b want 1", oinv8); else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    int sent = 0;
    int rcv  = 0;
    do_reset();
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      v4    = (sent < 10);
      d4    = blk(sent);
      inv4  = sent[0];
      ordy4 = !(cyc >= 3 && cyc <= 6);
      #1;
      if (cyc == 3) begin
        n_checks++;
`ifdef SHIFT_ROWS_SKID_EN
        if (rdy4 !== 1'b1) $display("FAIL stall_ready_c3 got %b want 1", rdy4); else n_pass++;
`else
        if (rdy4 !== 1'b0) $display("FAIL stall_ready_c3 got %b want 0", rdy4); else n_pass++;
`endif
      end
`ifdef SHIFT_ROWS_SKID_EN
      if (cyc == 4) begin
        n_checks++;
        if (rdy4 !== 1'b0) $display("FAIL stall_ready_c4 got %b want 0", rdy4); else n_pass++;
      end
`endif
      if (ov4) begin
        n_checks++;
        if (od4 !== blk(rcv) || oinv4 !== rcv[0])
          $display("FAIL stream_blk%0d got %h/%b want %h/%b", rcv, od4, oinv4, blk(rcv), rcv[0]);
        else n_pass++;
        if (ordy4) rcv++;
      end
      if (v4 && rdy4) sent++;
      tick();
    end
    v4 = 1'b0;
    #1;
    n_checks++; if (rcv != 10) $display("FAIL stream_rcv got %0d want 10", rcv); else n_pass++;
    n_checks++; if (sent != 10) $display("FAIL stream_sent got %0d want 10", sent); else n_pass++;
    n_checks++; if (cnt4 !== 16'd10) $display("FAIL stream_count got %0d want 10", cnt4); else n_pass++;
    n_checks++; if (ov4 !== 1'b0) $display("FAIL stream_extra got %b want 0", ov4); else n_pass++;
  endtask

  task automatic test_reset_mid();
    v4 = 1'b1; d4 = blk(20); inv4 = 1'b0; ordy4 = 1'b0;
    tick();
    d4 = blk(21); inv4 = 1'b1;
    tick();
    v4 = 1'b0;
    #1;
    n_checks++; if (ov4 !== 1'b1) $display("FAIL mid_setup got %b want 1", ov4); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (rdy4 !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", rdy4); else n_pass++;
    tick();
    n_checks++; if (ov4 !== 1'b0) $display("FAIL mid_valid got %b want 0", ov4); else n_pass++;
    n_checks++; if (cnt4 !== 16'd0) $display("FAIL mid_count got %0d want 0", cnt4); else n_pass++;
    n_checks++; if (od4 !== '0) $display("FAIL mid_data got %h want 0", od4); else n_pass++;
    rst = 1'b0; ordy4 = 1'b1;
    v4 = 1'b1; d4 = VecA; inv4 = 1'b0;
    #1;
    n_checks++; if (rdy4 !== 1'b1) $display("FAIL mid_first_ready got %b want 1", rdy4); else n_pass++;
    tick();
    v4 = 1'b0;
    #1;
    n_checks++; if (ov4 !== 1'b1 || od4 !== VecB)
      $display("FAIL mid_first_blk got %b/%h want 1/%h", ov4, od4, VecB); else n_pass++;
    tick();
    n_checks++; if (ov4 !== 1'b0) $display("FAIL mid_no_ghost got %b want 0", ov4); else n_pass++;
    n_checks++; if (cnt4 !== 16'd1) $display("FAIL mid_count1 got %0d want 1", cnt4); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    v8 = 1'b1; d8 = nb8_in(); inv8 = 1'b0; ordy8 = 1'b1;
    repeat (17) tick();
    v8 = 1'b0;
    n_checks++; if (cnt8 !== 4'd0) $display("FAIL wrap_16 got %0d want 0", cnt8); else n_pass++;
    tick();
    n_checks++; if (cnt8 !== 4'd1) $display("FAIL wrap_17 got %0d want 1", cnt8); else n_pass++;
    n_checks++; if (ov8 !== 1'b0) $display("FAIL wrap_drain got %b want 0", ov8); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_inverse();
    test_back_to_back();
    test_nb8();
    test_stream();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
